// File: rtl/lock_entry_controller.sv
// Keypad sequencer in front of the password comparator.
// Turns key strobes into comparator pulses and tracks unlock and lockout status.
//
// Parameters:
//   MAX_DIGITS      digit slots, width of cs (1..6)
//   MIN_DIGITS      fewest digits accepted for a compare or a new password
//   UNLOCK_CYCLES   cycles that unlocked stays high after a match
//   MAX_FAILS       consecutive mismatches before lockout
//   LOCKOUT_CYCLES  lockout duration
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   key_valid         one-cycle key strobe
//   key_code          0-9 digit, 4'hA enter, 4'hB clear/set; other codes ignored
//   key_ready         keys accepted in IDLE/ENTRY/UNLOCKED/SET only
//   correct           comparator match flag, sampled in CHECK
//   data, cs          registered digit and one-hot slot strobe
//   digit_count       digits entered this attempt
//   wr                answer write enable, high throughout SET
//   compare           one-cycle pulse in COMPARE
//   buf_clear         one-cycle pulse that clears the input buffer
//   initialize        one-cycle pulse that clears the answer buffer
//   unlocked, alarm   display status
// Build option: define LOCK_ENTRY_LOCKOUT_EN to enable the fail counter
// and the LOCKOUT state. Without it, alarm is tied low.
module lock_entry_controller #(
  parameter int MAX_DIGITS     = 6,
  parameter int MIN_DIGITS     = 4,
  parameter int UNLOCK_CYCLES  = 50,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic                  key_ready,
  input  logic                  correct,
  output logic [3:0]            data,
  output logic [MAX_DIGITS-1:0] cs,
  output logic [2:0]            digit_count,
  output logic                  wr,
  output logic                  compare,
  output logic                  buf_clear,
  output logic                  initialize,
  output logic                  unlocked,
  output logic                  alarm
);

  localparam logic [3:0] K_STAR = 4'hA;
  localparam logic [3:0] K_HASH = 4'hB;
  localparam logic [2:0] MAXD = 3'(MAX_DIGITS);
  localparam logic [2:0] MIND = 3'(MIN_DIGITS);

  // One timer serves both UNLOCKED and LOCKOUT.
  localparam int TMAX =
    (LOCKOUT_CYCLES > UNLOCK_CYCLES) ?
    LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_UNL =
    TW'(UNLOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_COMPARE,
    S_CHECK,
    S_UNLOCKED,
    S_SET,
    S_LOCKOUT
  } state_t;

  state_t state, state_n;

  logic [2:0]            count, count_n;
  logic [3:0]            data_n;
  logic [MAX_DIGITS-1:0] cs_n;
  logic                  bclr_n;
  logic                  init_n;
  logic [TW-1:0]         timer, timer_n;
  logic                  boot;
  logic                  mismatch;

  logic take;
  logic is_digit;
  logic is_star;
  logic is_hash;
  logic dig_ok;

`ifdef LOCK_ENTRY_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [FW-1:0] FMAX =
    FW'(MAX_FAILS);
  localparam logic [TW-1:0] T_LCK =
    TW'(LOCKOUT_CYCLES - 1);

  logic [FW-1:0] fails, fails_n;
  logic [FW-1:0] fails_inc;

  assign fails_inc = fails + FW'(1);
`else
  logic unused_fail_cfg;

  assign unused_fail_cfg = ^MAX_FAILS;
`endif

  assign key_ready = (state == S_IDLE)
                   | (state == S_ENTRY)
                   | (state == S_UNLOCKED)
                   | (state == S_SET);

  assign take     = key_valid & key_ready;
  assign is_digit = key_code <= 4'd9;
  assign is_star  = key_code == K_STAR;
  assign is_hash  = key_code == K_HASH;
  assign dig_ok   = take & is_digit
                  & (count < MAXD);

  assign wr          = state == S_SET;
  assign compare     = state == S_COMPARE;
  assign unlocked    = (state == S_UNLOCKED)
                     | (state == S_SET);
  assign digit_count = count;

`ifdef LOCK_ENTRY_LOCKOUT_EN
  assign alarm = state == S_LOCKOUT;
`else
  assign alarm = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    count_n  = count;
    data_n   = data;
    cs_n     = '0;
    // First cycle after reset release clears the input buffer.
    bclr_n   = boot;
    init_n   = 1'b0;
    timer_n  = timer;
    mismatch = 1'b0;
`ifdef LOCK_ENTRY_LOCKOUT_EN
    fails_n  = fails;
`endif

    // Digits load a slot in the three entry-capable states.
    if (dig_ok &&
        (state == S_IDLE ||
         state == S_ENTRY ||
         state == S_SET)) begin
      data_n  = key_code;
      cs_n    = MAX_DIGITS'(1) << count;
      count_n = count + 3'd1;
    end

    unique case (state)
      S_IDLE: begin
        if (dig_ok) state_n = S_ENTRY;
      end
      S_ENTRY: begin
        if (take && is_hash) begin
          bclr_n  = 1'b1;
          count_n = '0;
          state_n = S_IDLE;
        end else if (take && is_star) begin
          // Short entries are scored as a mismatch.
          if (count >= MIND) state_n = S_COMPARE;
          else mismatch = 1'b1;
        end
      end
      S_COMPARE: begin
        state_n = S_CHECK;
      end
      S_CHECK: begin
        bclr_n  = 1'b1;
        count_n = '0;
        if (correct) begin
          state_n = S_UNLOCKED;
          timer_n = T_UNL;
`ifdef LOCK_ENTRY_LOCKOUT_EN
          fails_n = '0;
`endif
        end else begin
          mismatch = 1'b1;
        end
      end
      S_UNLOCKED: begin
        if (take && is_hash) begin
          state_n = S_SET;
          init_n  = 1'b1;
          count_n = '0;
        end else if (timer == '0) begin
          state_n = S_IDLE;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      S_SET: begin
        if (take && is_star &&
            count >= MIND) begin
          bclr_n  = 1'b1;
          count_n = '0;
          state_n = S_IDLE;
        end else if (take && is_hash) begin
          init_n  = 1'b1;
          count_n = '0;
        end
      end
`ifdef LOCK_ENTRY_LOCKOUT_EN
      S_LOCKOUT: begin
        if (timer == '0) begin
          state_n = S_IDLE;
          fails_n = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
`endif
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (mismatch) begin
      bclr_n  = 1'b1;
      count_n = '0;
`ifdef LOCK_ENTRY_LOCKOUT_EN
      fails_n = fails_inc;
      if (fails_inc >= FMAX) begin
        state_n = S_LOCKOUT;
        timer_n = T_LCK;
      end else begin
        state_n = S_IDLE;
      end
`else
      state_n = S_IDLE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      count      <= '0;
      data       <= '0;
      cs         <= '0;
      buf_clear  <= 1'b0;
      initialize <= 1'b0;
      timer      <= '0;
      boot       <= 1'b1;
`ifdef LOCK_ENTRY_LOCKOUT_EN
      fails      <= '0;
`endif
    end else begin
      state      <= state_n;
      count      <= count_n;
      data       <= data_n;
      cs         <= cs_n;
      buf_clear  <= bclr_n;
      initialize <= init_n;
      timer      <= timer_n;
      boot       <= 1'b0;
`ifdef LOCK_ENTRY_LOCKOUT_EN
      fails      <= fails_n;
`endif
    end
  end

endmodule

// File: tb/tb_lock_entry_controller.sv
// Randomized bench for lock_entry_controller.
// A behavioural model predicts every output each cycle.
module tb_lock_entry_controller;

  localparam int MAXD  = 6;
  localparam int MIND  = 4;
  localparam int UCYC  = 50;
  localparam int MFAIL = 3;
  localparam int LCYC  = 1000;
  localparam logic [3:0] STAR = 4'hA;
  localparam logic [3:0] HASH = 4'hB;
`ifdef LOCK_ENTRY_LOCKOUT_EN
  localparam int LOCK_ON = 1;
`else
  localparam int LOCK_ON = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic key_valid;
  logic [3:0] key_code;
  logic key_ready;
  logic correct;
  logic [3:0] data;
  logic [MAXD-1:0] cs;
  logic [2:0] digit_count;
  logic wr;
  logic compare;
  logic buf_clear;
  logic initialize;
  logic unlocked;
  logic alarm;

  lock_entry_controller dut (
    .clk(clk),
    .reset(reset),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ready(key_ready),
    .correct(correct),
    .data(data),
    .cs(cs),
    .digit_count(digit_count),
    .wr(wr),
    .compare(compare),
    .buf_clear(buf_clear),
    .initialize(initialize),
    .unlocked(unlocked),
    .alarm(alarm)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ul_cnt = 0;
  int al_cnt = 0;
  bit hold_cor = 1'b0;

  // Model: mode name, digits held, fails, cycles left in timed modes.
  string mode = "idle";
  int cnt = 0;
  int fails = 0;
  int left = 0;
  bit boot = 1'b0;
  int m_data = 0;
  int m_cs = 0;
  bit m_bc = 1'b0;
  bit m_init = 1'b0;

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return mode == "idle" || mode == "entry" ||
           mode == "open" || mode == "set";
  endfunction

  task automatic lose();
    m_bc = 1'b1;
    cnt = 0;
    if (LOCK_ON != 0) begin
      fails++;
      if (fails >= MFAIL) begin
        mode = "lock";
        left = LCYC;
      end else begin
        mode = "idle";
      end
    end else begin
      mode = "idle";
    end
  endtask

  task automatic step(bit r, bit kv,
                      logic [3:0] kc, bit cor);
    bit acc;
    m_cs = 0;
    m_bc = 1'b0;
    m_init = 1'b0;
    if (!r) begin
      mode = "idle";
      cnt = 0;
      fails = 0;
      left = 0;
      m_data = 0;
      boot = 1'b1;
      return;
    end
    m_bc = boot;
    boot = 1'b0;
    acc = kv && m_ready();
    if (acc && kc <= 9 && cnt < MAXD &&
        (mode == "idle" || mode == "entry" ||
         mode == "set")) begin
      m_data = int'(kc);
      m_cs = 1 << cnt;
      cnt++;
      if (mode == "idle") mode = "entry";
      return;
    end
    if (mode == "entry") begin
      if (acc && kc == HASH) begin
        m_bc = 1'b1;
        cnt = 0;
        mode = "idle";
      end else if (acc && kc == STAR) begin
        if (cnt >= MIND) mode = "cmp";
        else lose();
      end
    end else if (mode == "cmp") begin
      mode = "chk";
    end else if (mode == "chk") begin
      m_bc = 1'b1;
      cnt = 0;
      if (cor) begin
        mode = "open";
        left = UCYC;
        fails = 0;
      end else begin
        lose();
      end
    end else if (mode == "open") begin
      if (acc && kc == HASH) begin
        mode = "set";
        m_init = 1'b1;
        cnt = 0;
      end else begin
        left--;
        if (left == 0) mode = "idle";
      end
    end else if (mode == "set") begin
      if (acc && kc == STAR && cnt >= MIND) begin
        m_bc = 1'b1;
        cnt = 0;
        mode = "idle";
      end else if (acc && kc == HASH) begin
        m_init = 1'b1;
        cnt = 0;
      end
    end else if (mode == "lock") begin
      left--;
      if (left == 0) begin
        mode = "idle";
        fails = 0;
      end
    end
  endtask

  task automatic check_all();
    if (unlocked === 1'b1) ul_cnt++;
    if (alarm === 1'b1) al_cnt++;
    chk("data", 32'(data), 32'(m_data));
    chk("cs", 32'(cs), 32'(m_cs));
    chk("digit_count", 32'(digit_count), 32'(cnt));
    chk("wr", 32'(wr), 32'(mode == "set"));
    chk("compare", 32'(compare),
        32'(mode == "cmp"));
    chk("buf_clear", 32'(buf_clear), 32'(m_bc));
    chk("initialize", 32'(initialize),
        32'(m_init));
    chk("unlocked", 32'(unlocked),
        32'(mode == "open" || mode == "set"));
    chk("alarm", 32'(alarm), 32'(mode == "lock"));
    chk("key_ready", 32'(key_ready),
        32'(m_ready()));
  endtask

  task automatic cyc(bit r, bit kv,
                     logic [3:0] kc, bit cor);
    @(negedge clk);
    check_all();
    reset = r;
    key_valid = kv;
    key_code = kc;
    correct = cor;
    @(posedge clk);
    step(r, kv, kc, cor);
  endtask

  task automatic press(logic [3:0] kc);
    cyc(1'b1, 1'b1, kc, hold_cor);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b1, 1'b0, 4'h0, hold_cor);
  endtask

  task automatic code4();
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    press(STAR);
  endtask

  initial begin
    reset = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    correct = 1'b0;
    step(1'b0, 1'b0, 4'h0, 1'b0);

    // reset held, then released
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    idle(3);

    // good code, unlock window length
    hold_cor = 1'b1;
    ul_cnt = 0;
    code4();
    idle(60);
    chk("unlock_len", 32'(ul_cnt), 32'(UCYC));

    // short entry, then digit overflow
    hold_cor = 1'b0;
    press(4'd1);
    press(4'd2);
    press(STAR);
    idle(3);
    for (int i = 1; i <= 7; i++)
      press(4'(i));
    idle(2);
    chk("count_cap", 32'(digit_count), 32'(MAXD));
    press(HASH);
    idle(2);

    // password change
    hold_cor = 1'b1;
    code4();
    idle(5);
    press(HASH);
    press(4'd9);
    press(4'd8);
    press(4'd7);
    press(4'd6);
    press(4'd5);
    idle(1);
    press(STAR);
    idle(3);

    // reset in the middle of SET
    code4();
    idle(4);
    press(HASH);
    press(4'd9);
    press(4'd8);
    press(4'd7);
    cyc(1'b0, 1'b1, 4'd6, 1'b1);
    idle(3);

    // repeated mismatches, keys during lockout
    hold_cor = 1'b0;
    cyc(1'b0, 1'b0, 4'h0, 1'b0);
    idle(1);
    al_cnt = 0;
    repeat (3) begin
      code4();
      idle(3);
    end
    for (int i = 0; i < LCYC + 10; i++)
      cyc(1'b1, 1'b1, 4'($urandom % 16), 1'b0);
    idle(3);
    chk("alarm_len", 32'(al_cnt),
        32'(LOCK_ON != 0 ? LCYC : 0));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int p;
      logic [3:0] k;
      p = int'($urandom % 100);
      if (p < 60) k = 4'($urandom % 10);
      else if (p < 78) k = STAR;
      else if (p < 90) k = HASH;
      else k = 4'(12 + $urandom % 4);
      cyc(($urandom % 300) != 0,
          ($urandom % 2) != 0, k,
          ($urandom % 2) != 0);
    end
    @(negedge clk);
    check_all();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
